// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types, defaults and sizing helpers for byte_serializer
package serializer_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serializer_bit_counter.sv
// rtl/serializer_bit_counter.sv - clear/enable up-counter with terminal-count flag
module serializer_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  // Clear wins over enable so a reload always restarts the sequence at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - valid/ready parallel-in, serial-out stage; SERIALIZER_PARITY_EN appends an even-parity bit
module byte_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ser_out,
  output logic              ser_en,
  output logic              ser_last,
  output logic              busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CW = cnt_width(DATA_W);
  localparam int GW = cnt_width(15);
  localparam logic [CW-1:0] BIT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  state_t            state, state_n;
  logic              pend_full, pend_full_n;
  logic [DATA_W-1:0] pend_data;
  logic [DATA_W-1:0] frame_q, frame_src;
  logic [CW-1:0]     bit_cnt, next_idx;
  logic              bit_tc;
  logic [GW-1:0]     gap_cnt;
  logic              gap_tc;
  logic              gap_cnt_unused;
  logic              accept, load;
  logic              ser_out_d, ser_en_d, ser_last_d, busy_d;

  // Bit of frame f sent at position idx, honouring the bit order and trailing parity.
  function automatic logic bit_at(input logic [DATA_W-1:0] f, input logic [CW-1:0] idx);
    logic [DATA_W-1:0] ord;
    logic              b;
    for (int i = 0; i < DATA_W; i++) begin
      ord[i] = (MSB_FIRST != 0) ? f[i] : f[DATA_W-1-i];
    end
    ord = ord << idx;
    b   = ord[DATA_W-1];
`ifdef SERIALIZER_PARITY_EN
    if (idx == CW'(DATA_W)) begin
      b = ^f;
    end
`endif
    return b;
  endfunction

  assign din_ready      = ~pend_full;
  assign accept         = din_valid & din_ready;
  assign gap_cnt_unused = ^gap_cnt;

  serializer_bit_counter #(.W(CW)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (load),
    .en    ((state == SHIFT) && !bit_tc),
    .last  (BIT_LAST),
    .count (bit_cnt),
    .tc    (bit_tc)
  );

  serializer_bit_counter #(.W(GW)) u_gap_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear ((state == SHIFT) && bit_tc),
    .en    ((state == GAP) && !gap_tc),
    .last  (GAP_LAST),
    .count (gap_cnt),
    .tc    (gap_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state; load marks the edge that moves pend into the shifter.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_full) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_tc) begin
          if (HAS_GAP) begin
            state_n = GAP;
          end else if (pend_full) begin
            load    = 1'b1;
            state_n = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_tc) begin
          if (pend_full) begin
            load    = 1'b1;
            state_n = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode: values the registered outputs take after the coming edge.
  always_comb begin
    pend_full_n = pend_full;
    if (accept) begin
      pend_full_n = 1'b1;
    end else if (load) begin
      pend_full_n = 1'b0;
    end
    frame_src  = load ? pend_data : frame_q;
    next_idx   = load ? '0 : bit_cnt + CW'(1);
    ser_en_d   = (state_n == SHIFT);
    ser_out_d  = ser_en_d & bit_at(frame_src, next_idx);
    ser_last_d = ser_en_d & (next_idx == BIT_LAST);
    busy_d     = (state_n != IDLE) | pend_full_n;
  end

  // One-deep pending buffer; accept and load never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full <= 1'b0;
      pend_data <= '0;
    end else begin
      pend_full <= pend_full_n;
      if (accept) begin
        pend_data <= din;
      end
    end
  end

  // Frame being shifted, captured from pend on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
    end else if (load) begin
      frame_q <= pend_data;
    end
  end

  // Registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_out  <= 1'b0;
      ser_en   <= 1'b0;
      ser_last <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ser_out  <= ser_out_d;
      ser_en   <= ser_en_d;
      ser_last <= ser_last_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// tb/tb_byte_serializer.sv - randomized and directed bench for byte_serializer, gap 0 and gap 2 lanes
module tb_byte_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int FL = 9;
  localparam logic [7:0] Q_A5 = 8'h4A;
  localparam logic [7:0] Q_07 = 8'h0F;
  localparam logic [7:0] Q_3C = 8'h78;
  localparam logic [7:0] Q_11 = 8'h22;
  localparam logic [7:0] Q_0F = 8'h1E;
`else
  localparam int FL = 8;
  localparam logic [7:0] Q_A5 = 8'hA5;
  localparam logic [7:0] Q_07 = 8'h07;
  localparam logic [7:0] Q_3C = 8'h3C;
  localparam logic [7:0] Q_11 = 8'h11;
  localparam logic [7:0] Q_0F = 8'h0F;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit done [2];

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got %0h expected %0h at %0t", g, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int GAP = 2 * g;

    logic       rst;
    logic [7:0] din;
    logic       din_valid, din_ready, ser_out, ser_en, ser_last, busy;

    byte_serializer #(.DATA_W(8), .MSB_FIRST(1), .GAP_CYCLES(GAP)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .ser_out   (ser_out),
      .ser_en    (ser_en),
      .ser_last  (ser_last),
      .busy      (busy)
    );

    // Reference: queue of upcoming output cycles {en, out, last}; front is what is shown now.
    logic [2:0] sched [$];
    bit         m_full = 1'b0;
    bit         m_acc;
    logic [7:0] m_pend;

    task automatic push_frame(input logic [7:0] d);
      for (int i = 0; i < 8; i++) sched.push_back({1'b1, d[7-i], (i == FL - 1)});
`ifdef SERIALIZER_PARITY_EN
      sched.push_back({1'b1, ^d, 1'b1});
`endif
      for (int i = 0; i < GAP; i++) sched.push_back(3'b000);
    endtask

    initial begin : model
      forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
          sched.delete();
          m_full = 1'b0;
        end else begin
          m_acc = din_valid && !m_full;
          if (sched.size() != 0) void'(sched.pop_front());
          if (sched.size() == 0 && m_full) begin
            push_frame(m_pend);
            m_full = 1'b0;
          end
          if (m_acc) begin
            m_full = 1'b1;
            m_pend = din;
          end
        end
      end
    end

    initial begin : compare
      logic [2:0] e;
      forever begin
        @(negedge clk);
        e = (sched.size() != 0) ? sched[0] : 3'b000;
        check("ser_en", g, 32'(ser_en), 32'(e[2]));
        check("ser_out", g, 32'(ser_out), 32'(e[1]));
        check("ser_last", g, 32'(ser_last), 32'(e[0]));
        check("busy", g, 32'(busy), 32'(sched.size() != 0 || m_full));
        check("din_ready", g, 32'(din_ready), 32'(!m_full));
      end
    end

    // Downstream 8-bit shift-left register plus frame statistics.
    logic [7:0] q_down = 8'h00;
    int en_cnt, last_cnt, run, max_run, zeros, between, pend_bl, busy_low;
    bit seen;

    always @(posedge clk) begin
      if (ser_en) begin
        q_down   <= {q_down[6:0], ser_out};
        en_cnt   <= en_cnt + 1;
        run      <= run + 1;
        if (run + 1 > max_run) max_run <= run + 1;
        if (ser_last) last_cnt <= last_cnt + 1;
        if (seen) begin
          between  <= between + zeros;
          busy_low <= busy_low + pend_bl;
        end
        zeros   <= 0;
        pend_bl <= 0;
        seen    <= 1'b1;
      end else begin
        run <= 0;
        if (seen) begin
          zeros <= zeros + 1;
          if (!busy) pend_bl <= pend_bl + 1;
        end
      end
    end

    task automatic clr_stats();
      en_cnt = 0; last_cnt = 0; run = 0; max_run = 0; zeros = 0;
      between = 0; pend_bl = 0; busy_low = 0; seen = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
      int t = 0;
      din = d;
      din_valid = 1'b1;
      while (!din_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("send_accepted", g, 32'(din_ready), 32'd1);
      @(negedge clk);
      din_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int t = 0;
      while ((busy || ser_en) && t < 300) begin
        @(negedge clk);
        t++;
      end
      check("idle_reached", g, 32'(busy), 32'd0);
    endtask

    initial begin : drive
      rst = 1'b1;
      din = 8'h00;
      din_valid = 1'b0;
      clr_stats();
      repeat (3) @(negedge clk);
      check("reset_busy", g, 32'(busy), 32'd0);
      check("reset_ready", g, 32'(din_ready), 32'd1);
      check("reset_en", g, 32'(ser_en), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single frame: first bit one edge after the accept edge.
      clr_stats();
      send(8'hA5);
      @(negedge clk);
      check("first_en", g, 32'(ser_en), 32'd1);
      check("first_bit", g, 32'(ser_out), 32'd1);
      wait_idle();
      check("a5_q", g, 32'(q_down), 32'(Q_A5));
      check("a5_len", g, 32'(en_cnt), 32'(FL));
      check("a5_last", g, 32'(last_cnt), 32'd1);

      clr_stats();
      send(8'h07);
      wait_idle();
      check("07_q", g, 32'(q_down), 32'(Q_07));

      // Two queued frames: run length and inter-frame gap.
      clr_stats();
      send(8'hA5);
      send(8'h3C);
      check("b2b_ready_low", g, 32'(din_ready), 32'd0);
      wait_idle();
      check("b2b_q", g, 32'(q_down), 32'(Q_3C));
      check("b2b_len", g, 32'(en_cnt), 32'(2 * FL));
      check("b2b_maxrun", g, 32'(max_run), 32'((GAP == 0) ? 2 * FL : FL));
      check("b2b_gap", g, 32'(between), 32'(GAP));
      check("b2b_busy", g, 32'(busy_low), 32'd0);

      // Backpressure: 0x11 held while pend is full.
      clr_stats();
      send(8'h22);
      send(8'h33);
      din = 8'h11;
      din_valid = 1'b1;
      check("bp_ready_low", g, 32'(din_ready), 32'd0);
      send(8'h11);
      wait_idle();
      check("bp_frames", g, 32'(last_cnt), 32'd3);
      check("bp_q", g, 32'(q_down), 32'(Q_11));

      // Reset between edges after three bits of 0xFF.
      clr_stats();
      send(8'hFF);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_en", g, 32'(ser_en), 32'd0);
      check("rst_out", g, 32'(ser_out), 32'd0);
      check("rst_ready", g, 32'(din_ready), 32'd1);
      check("rst_busy", g, 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      clr_stats();
      send(8'h0F);
      wait_idle();
      check("rst_q", g, 32'(q_down), 32'(Q_0F));
      check("rst_len", g, 32'(en_cnt), 32'(FL));
      check("rst_last", g, 32'(last_cnt), 32'd1);

      // Random traffic; din held stable while stalled.
      for (int c = 0; c < 600; c++) begin
        if (!(din_valid && !din_ready)) begin
          din_valid = ($urandom_range(0, 3) != 0);
          din = 8'($urandom);
        end
        @(negedge clk);
      end
      din_valid = 1'b0;
      wait_idle();
      done[g] = 1'b1;
    end
  end

  initial begin : finish
    int t = 0;
    while (!(done[0] && done[1]) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!(done[0] && done[1])) begin
      n_cmp++;
      n_fail++;
      $display("FAIL lanes_done: got %0b%0b expected 11", done[1], done[0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
